// File: rtl/port_egress_sgdma_if.sv
// MMU packet-read channel between the egress scatter-gather DMA and the MMU.
// master = DMA side (requests, stall, done), slave = MMU side (ready, beats).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_DWIDTH
`define DATA_DWIDTH 32
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 30
`endif

interface port_egress_sgdma_if;
    logic                    mmu_rd_req;
    logic [`ADDR_WIDTH-1:0]  mmu_rd_addr;
    logic [6:0]              mmu_rd_len;
    logic                    mmu_rd_ready;
    logic                    mmu_rd_vld;
    logic [`DATA_DWIDTH-1:0] mmu_rd_dat;
    logic [`ADDR_WIDTH-1:0]  mmu_rd_cell_addr;
    logic                    mmu_rd_stall;
    logic                    mmu_rd_done;

    modport master (
        output mmu_rd_req, mmu_rd_addr, mmu_rd_len,
        output mmu_rd_stall, mmu_rd_done,
        input  mmu_rd_ready, mmu_rd_vld,
        input  mmu_rd_dat, mmu_rd_cell_addr
    );

    modport slave (
        input  mmu_rd_req, mmu_rd_addr, mmu_rd_len,
        input  mmu_rd_stall, mmu_rd_done,
        output mmu_rd_ready, mmu_rd_vld,
        output mmu_rd_dat, mmu_rd_cell_addr
    );
endinterface

// File: rtl/port_egress_sgdma.sv
// Egress SG-DMA: pops a crossbar descriptor, reads the packet from the MMU,
// streams cells to the output FIFO and frees them. Optional: EGRESS_STAT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_DWIDTH
`define DATA_DWIDTH 32
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 30
`endif

module port_egress_sgdma #(
    parameter int unsigned port = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [`DISPATCH_WIDTH-1:0] i_cb_dout,
    input  logic                       i_cb_empty,
    output logic                       o_cb_rd_en,
    port_egress_sgdma_if.master        mmu,
    output logic                       o_wr_en,
    output logic [`DATA_DWIDTH-1:0]    o_dat,
    output logic                       o_sop,
    output logic                       o_eop,
    input  logic                       i_full,
    output logic                       o_fp_rls_en,
    output logic [`ADDR_WIDTH-1:0]     o_fp_rls_addr,
    output logic                       o_err
`ifdef EGRESS_STAT_EN
    ,
    output logic [31:0]                o_pkt_cnt,
    output logic [31:0]                o_cell_cnt
`endif
);

    localparam logic [3:0] PORT_ID = 4'(port);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [`ADDR_WIDTH-1:0]  addr_q;
    logic [6:0]              len_q;
    logic                    req_q;
    logic                    done_q;
    logic                    err_q;
    logic [6:0]              in_cnt_q;
    logic [6:0]              out_cnt_q;

    logic [1:0]              cnt_q, cnt_d;
    logic [`DATA_DWIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [`ADDR_WIDTH-1:0]  a0_q, a0_d, a1_q, a1_d;

    logic                    wr;
    logic                    beat;
    logic                    push;
    logic                    drop;
    logic [6:0]              f_len;
    logic [3:0]              f_dest;
    logic [2:0]              unused_prio;

    assign f_len       = i_cb_dout[13:7];
    assign f_dest      = i_cb_dout[3:0];
    assign unused_prio = i_cb_dout[6:4];

    // Combinational pop so the descriptor lands in FETCH one cycle later.
    assign o_cb_rd_en = i_rst_n & (state_q == S_IDLE) & ~i_cb_empty;

    assign wr   = (cnt_q != 2'd0) & ~i_full;
    assign beat = (state_q == S_STREAM) & mmu.mmu_rd_vld;
    assign push = beat & (cnt_q != 2'd2) & (in_cnt_q != len_q);
    assign drop = beat & (cnt_q == 2'd2);

    assign o_wr_en       = wr;
    assign o_dat         = d0_q;
    assign o_sop         = wr & (out_cnt_q == 7'd0);
    assign o_eop         = wr & ((out_cnt_q + 7'd1) == len_q);
    assign o_fp_rls_en   = wr;
    assign o_fp_rls_addr = a0_q;
    assign o_err         = err_q;

    assign mmu.mmu_rd_req   = req_q;
    assign mmu.mmu_rd_addr  = addr_q;
    assign mmu.mmu_rd_len   = len_q;
    assign mmu.mmu_rd_done  = done_q;
    assign mmu.mmu_rd_stall = (cnt_q == 2'd2) |
                              ((cnt_q != 2'd0) & i_full);

    // Two-entry skid buffer; entry 0 is always the head.
    always_comb begin
        cnt_d = cnt_q;
        d0_d  = d0_q;
        a0_d  = a0_q;
        d1_d  = d1_q;
        a1_d  = a1_q;
        case ({push, wr})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    d0_d = mmu.mmu_rd_dat;
                    a0_d = mmu.mmu_rd_cell_addr;
                end else begin
                    d1_d = mmu.mmu_rd_dat;
                    a1_d = mmu.mmu_rd_cell_addr;
                end
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                d0_d  = d1_q;
                a0_d  = a1_q;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    d0_d = mmu.mmu_rd_dat;
                    a0_d = mmu.mmu_rd_cell_addr;
                end else begin
                    d0_d = d1_q;
                    a0_d = a1_q;
                    d1_d = mmu.mmu_rd_dat;
                    a1_d = mmu.mmu_rd_cell_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            cnt_q     <= '0;
            d0_q      <= '0;
            a0_q      <= '0;
            d1_q      <= '0;
            a1_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            d0_q  <= d0_d;
            a0_q  <= a0_d;
            d1_q  <= d1_d;
            a1_q  <= a1_d;
            if (push) in_cnt_q <= in_cnt_q + 7'd1;
            if (wr) out_cnt_q <= out_cnt_q + 7'd1;
            if (drop) err_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (!i_cb_empty) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    addr_q    <= i_cb_dout[14 +: `ADDR_WIDTH];
                    len_q     <= f_len;
                    in_cnt_q  <= '0;
                    out_cnt_q <= '0;
                    if (f_len == 7'd0) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        if (f_dest != PORT_ID) err_q <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mmu.mmu_rd_ready) begin
                        req_q   <= 1'b0;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (o_eop) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef EGRESS_STAT_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] cell_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt_q  <= '0;
            cell_cnt_q <= '0;
        end else begin
            if (done_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (wr) cell_cnt_q <= cell_cnt_q + 32'd1;
        end
    end

    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_cell_cnt = cell_cnt_q;
`endif

endmodule

// File: tb/tb_port_egress_sgdma.sv
// Directed bench for port_egress_sgdma with crossbar FIFO and MMU models.
// Expected beat k of a packet at address A: data {16'hDA7A, A+k}, release A+k.
`timescale 1ns/1ps

module tb_port_egress_sgdma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] cb_dout = '0;
    logic        cb_empty;
    logic        cb_rd_en;
    logic        wr_en, sop, eop, full = 1'b0;
    logic [31:0] dat;
    logic        rls_en;
    logic [15:0] rls_addr;
    logic        err;
    logic        ready_en = 1'b1;
`ifdef EGRESS_STAT_EN
    logic [31:0] pkt_cnt, cell_cnt;
`endif

    port_egress_sgdma_if mmu_if ();

    port_egress_sgdma #(.port(0)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cb_dout     (cb_dout),
        .i_cb_empty    (cb_empty),
        .o_cb_rd_en    (cb_rd_en),
        .mmu           (mmu_if.master),
        .o_wr_en       (wr_en),
        .o_dat         (dat),
        .o_sop         (sop),
        .o_eop         (eop),
        .i_full        (full),
        .o_fp_rls_en   (rls_en),
        .o_fp_rls_addr (rls_addr),
        .o_err         (err)
`ifdef EGRESS_STAT_EN
        ,
        .o_pkt_cnt     (pkt_cnt),
        .o_cell_cnt    (cell_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [29:0] desc_mem [16];
    int wr_idx = 0;
    int rd_idx = 0;
    assign cb_empty = (wr_idx == rd_idx);

    always @(posedge clk) begin
        if (cb_rd_en) begin
            cb_dout <= desc_mem[rd_idx % 16];
            rd_idx  <= rd_idx + 1;
        end
    end

    // MMU: a beat in cycle t is withheld if stall was high in cycle t-1.
    int          m_left;
    logic [15:0] m_base, m_idx;
    assign mmu_if.mmu_rd_ready = ready_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_base <= '0;
            m_idx  <= '0;
            mmu_if.mmu_rd_vld       <= 1'b0;
            mmu_if.mmu_rd_dat       <= '0;
            mmu_if.mmu_rd_cell_addr <= '0;
        end else if (mmu_if.mmu_rd_req && ready_en) begin
            m_left <= int'(mmu_if.mmu_rd_len);
            m_base <= mmu_if.mmu_rd_addr;
            m_idx  <= '0;
            mmu_if.mmu_rd_vld <= 1'b0;
        end else if (m_left > 0 && !mmu_if.mmu_rd_stall) begin
            mmu_if.mmu_rd_vld       <= 1'b1;
            mmu_if.mmu_rd_dat       <= {16'hDA7A, 16'(m_base + m_idx)};
            mmu_if.mmu_rd_cell_addr <= m_base + m_idx;
            m_idx  <= m_idx + 16'd1;
            m_left <= m_left - 1;
        end else begin
            mmu_if.mmu_rd_vld <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Recorder only; comparisons live in the test tasks.
    logic [31:0] log_dat [64];
    logic [15:0] log_rla [64];
    logic [2:0]  log_flg [64];
    int nw = 0, ndone = 0, nreq = 0, nstall = 0, wr_full = 0;
    int req_cyc = 0, vld_rise = 0, sop_cyc = 0;
    logic [15:0] req_addr = '0;
    logic [6:0]  req_len = '0;
    logic        req_prev = 1'b0, vld_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            if (nw < 64) begin
                log_dat[nw] = dat;
                log_rla[nw] = rls_addr;
                log_flg[nw] = {sop, eop, rls_en};
            end
            nw = nw + 1;
            if (full) wr_full = wr_full + 1;
            if (sop) sop_cyc = cyc;
        end
        if (mmu_if.mmu_rd_done) ndone = ndone + 1;
        if (mmu_if.mmu_rd_stall) nstall = nstall + 1;
        if (mmu_if.mmu_rd_req && !req_prev) begin
            nreq     = nreq + 1;
            req_cyc  = cyc;
            req_addr = mmu_if.mmu_rd_addr;
            req_len  = mmu_if.mmu_rd_len;
        end
        if (mmu_if.mmu_rd_vld && !vld_prev) vld_rise = cyc;
        req_prev = mmu_if.mmu_rd_req;
        vld_prev = mmu_if.mmu_rd_vld;
    end

    wire [8:0] outs = {cb_rd_en, mmu_if.mmu_rd_req, wr_en, sop, eop,
                       rls_en, mmu_if.mmu_rd_done, err,
                       mmu_if.mmu_rd_stall};

    function automatic logic [29:0] desc(input logic [15:0] a,
                                         input logic [6:0] n,
                                         input logic [3:0] d);
        return {a, n, 3'd2, d};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int push_cyc = 0;
    task automatic push(input logic [29:0] w);
        desc_mem[wr_idx % 16] = w;
        wr_idx   = wr_idx + 1;
        push_cyc = cyc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ndone >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_writes(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (nw >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (outs !== 9'd0) $display("FAIL reset_outs got=%b exp=0", outs);
        else passes++;
        checks++;
        if ({mmu_if.mmu_rd_addr, mmu_if.mmu_rd_len} !== 23'd0)
            $display("FAIL reset_addr_len got=%h exp=0",
                     {mmu_if.mmu_rd_addr, mmu_if.mmu_rd_len});
        else passes++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int nw0 = nw, nd0 = ndone;
        int pc;
        bit ok;
        logic [15:0] a;
        push(desc(16'h0040, 7'd3, 4'd0));
        pc = push_cyc;
        wait_done(nd0 + 1, ok);
        tick(3);
        checks++;
        if (ok !== 1'b1) $display("FAIL basic_timeout got=%0d exp=1", ok);
        else passes++;
        checks++;
        if (req_addr !== 16'h0040) $display("FAIL basic_req_addr got=%h exp=0040", req_addr);
        else passes++;
        checks++;
        if (req_len !== 7'd3) $display("FAIL basic_req_len got=%0d exp=3", req_len);
        else passes++;
        checks++;
        if (req_cyc - pc !== 2) $display("FAIL basic_req_latency got=%0d exp=2", req_cyc - pc);
        else passes++;
        checks++;
        if (sop_cyc - vld_rise !== 1) $display("FAIL basic_beat_latency got=%0d exp=1", sop_cyc - vld_rise);
        else passes++;
        checks++;
        if (nw - nw0 !== 3) $display("FAIL basic_writes got=%0d exp=3", nw - nw0);
        else passes++;
        for (int k = 0; k < 3; k++) begin
            a = 16'h0040 + 16'(k);
            checks++;
            if ({log_flg[nw0+k], log_rla[nw0+k], log_dat[nw0+k]} !==
                {k == 0, k == 2, 1'b1, a, 16'hDA7A, a})
                $display("FAIL basic_beat%0d got=%b/%h/%h exp=%b%b1/%h/DA7A%h", k,
                         log_flg[nw0+k], log_rla[nw0+k], log_dat[nw0+k], k == 0, k == 2, a, a);
            else passes++;
        end
        checks++;
        if (ndone - nd0 !== 1) $display("FAIL basic_done got=%0d exp=1", ndone - nd0);
        else passes++;
        checks++;
        if (err !== 1'b0) $display("FAIL basic_err got=%b exp=0", err);
        else passes++;
    endtask

    task automatic test_len1();
        int nw0 = nw, nd0 = ndone;
        bit ok;
        push(desc(16'h0100, 7'd1, 4'd0));
        wait_done(nd0 + 1, ok);
        tick(3);
        checks++;
        if (nw - nw0 !== 1) $display("FAIL len1_writes got=%0d exp=1", nw - nw0);
        else passes++;
        checks++;
        if ({log_flg[nw0], log_rla[nw0], log_dat[nw0]} !== {3'b111, 16'h0100, 32'hDA7A_0100})
            $display("FAIL len1_beat got=%b/%h/%h exp=111/0100/DA7A0100",
                     log_flg[nw0], log_rla[nw0], log_dat[nw0]);
        else passes++;
        checks++;
        if (ndone - nd0 !== 1) $display("FAIL len1_done got=%0d exp=1", ndone - nd0);
        else passes++;
    endtask

    task automatic test_full();
        int nw0 = nw, nd0 = ndone, ns0 = nstall, wf0 = wr_full;
        bit ok, ok2;
        logic [15:0] a;
        ready_en = 1'b0;
        push(desc(16'h0200, 7'd8, 4'd0));
        tick(6);
        checks++;
        if ({mmu_if.mmu_rd_req, 6'(nw - nw0)} !== 7'b1_000000)
            $display("FAIL full_req_hold got=%b/%0d exp=1/0", mmu_if.mmu_rd_req, nw - nw0);
        else passes++;
        ready_en = 1'b1;
        wait_writes(nw0 + 3, ok);
        full = 1'b1;
        tick(5);
        full = 1'b0;
        wait_done(nd0 + 1, ok2);
        tick(3);
        checks++;
        if ({ok, ok2} !== 2'b11) $display("FAIL full_timeout got=%b%b exp=11", ok, ok2);
        else passes++;
        checks++;
        if (nstall - ns0 < 1) $display("FAIL full_stall got=%0d exp>=1", nstall - ns0);
        else passes++;
        checks++;
        if (wr_full - wf0 !== 0) $display("FAIL full_wr_while_full got=%0d exp=0", wr_full - wf0);
        else passes++;
        checks++;
        if (nw - nw0 !== 8) $display("FAIL full_writes got=%0d exp=8", nw - nw0);
        else passes++;
        for (int k = 0; k < 8; k++) begin
            a = 16'h0200 + 16'(k);
            checks++;
            if ({log_flg[nw0+k], log_rla[nw0+k], log_dat[nw0+k]} !==
                {k == 0, k == 7, 1'b1, a, 16'hDA7A, a})
                $display("FAIL full_beat%0d got=%b/%h/%h exp=%b%b1/%h", k,
                         log_flg[nw0+k], log_rla[nw0+k], log_dat[nw0+k], k == 0, k == 7, a);
            else passes++;
        end
    endtask

    task automatic test_err();
        int nw0, nd0, nr0;
        bit ok;
        do_reset();
        nw0 = nw;
        nd0 = ndone;
        push(desc(16'h0300, 7'd2, 4'd3));
        wait_done(nd0 + 1, ok);
        tick(2);
        checks++;
        if ({ok, err} !== 2'b11) $display("FAIL err_dest got=%b%b exp=11", ok, err);
        else passes++;
        checks++;
        if (nw - nw0 !== 2 || log_dat[nw0+1] !== 32'hDA7A_0301)
            $display("FAIL err_dest_delivery got=%0d/%h exp=2/DA7A0301", nw - nw0, log_dat[nw0+1]);
        else passes++;
        do_reset();
        checks++;
        if (err !== 1'b0) $display("FAIL err_reset_clear got=%b exp=0", err);
        else passes++;
        nr0 = nreq;
        push(desc(16'h0310, 7'd0, 4'd0));
        tick(8);
        checks++;
        if ({err, 4'(nreq - nr0)} !== 5'b1_0000)
            $display("FAIL err_len0 got=%b/%0d exp=1/0", err, nreq - nr0);
        else passes++;
        nd0 = ndone;
        push(desc(16'h0320, 7'd1, 4'd0));
        wait_done(nd0 + 1, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL err_recover got=%b exp=1", ok);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int nw0, nd0;
        bit ok;
        do_reset();
        nw0 = nw;
        nd0 = ndone;
        push(desc(16'h0400, 7'd5, 4'd0));
        wait_writes(nw0 + 2, ok);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({ok, outs} !== {1'b1, 9'd0}) $display("FAIL mid_reset_outs got=%b/%b exp=1/0", ok, outs);
        else passes++;
        tick();
        rst_n = 1'b1;
        tick(10);
        checks++;
        if ({6'(nw - nw0), 4'(ndone - nd0)} !== {6'd2, 4'd0})
            $display("FAIL mid_abandon got=%0d/%0d exp=2/0", nw - nw0, ndone - nd0);
        else passes++;
        nw0 = nw;
        nd0 = ndone;
        push(desc(16'h0500, 7'd2, 4'd0));
        wait_done(nd0 + 1, ok);
        tick(2);
        checks++;
        if ({ok, 6'(nw - nw0), err} !== {1'b1, 6'd2, 1'b0})
            $display("FAIL mid_restart got=%b/%0d/%b exp=1/2/0", ok, nw - nw0, err);
        else passes++;
        checks++;
        if ({log_flg[nw0], log_dat[nw0], log_flg[nw0+1], log_rla[nw0+1]} !==
            {3'b101, 32'hDA7A_0500, 3'b011, 16'h0501})
            $display("FAIL mid_restart_beats got=%b/%h/%b/%h exp=101/DA7A0500/011/0501",
                     log_flg[nw0], log_dat[nw0], log_flg[nw0+1], log_rla[nw0+1]);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int nw0, nd0;
        bit ok;
        do_reset();
        nw0 = nw;
        nd0 = ndone;
        push(desc(16'h0600, 7'd4, 4'd0));
        push(desc(16'h0700, 7'd2, 4'd0));
        wait_done(nd0 + 2, ok);
        tick(3);
        checks++;
        if ({ok, 6'(nw - nw0)} !== {1'b1, 6'd6})
            $display("FAIL b2b_writes got=%b/%0d exp=1/6", ok, nw - nw0);
        else passes++;
        checks++;
        if ({log_flg[nw0+3], log_flg[nw0+4], log_dat[nw0+4]} !==
            {3'b011, 3'b101, 32'hDA7A_0700})
            $display("FAIL b2b_boundary got=%b/%b/%h exp=011/101/DA7A0700",
                     log_flg[nw0+3], log_flg[nw0+4], log_dat[nw0+4]);
        else passes++;
`ifdef EGRESS_STAT_EN
        checks++;
        if ({pkt_cnt, cell_cnt} !== {32'd2, 32'd6})
            $display("FAIL stat_counts got=%0d/%0d exp=2/6", pkt_cnt, cell_cnt);
        else passes++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len1();
        test_full();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/port_egress_sgdma.md
PORT_EGRESS_SGDMA -- requirements
Module: port_egress_sgdma

Interface
REQ-001 Parameter: port, default 0, index of the egress port this instance serves.
REQ-002 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_cb_dout  in  `DISPATCH_WIDTH  crossbar output FIFO word: [29:14] first cell addr, [13:7] cell count, [6:4] priority, [3:0] dest port.
REQ-005 i_cb_empty  in  1  crossbar output FIFO empty.
REQ-006 o_cb_rd_en  out  1  crossbar FIFO read strobe; word valid on i_cb_dout the following cycle.
REQ-007 o_mmu_rd_req / o_mmu_rd_addr[`ADDR_WIDTH] / o_mmu_rd_len[7]  out  packet read request, first addr, cell count.
REQ-008 i_mmu_rd_ready  in  1  request accepted.
REQ-009 i_mmu_rd_vld / i_mmu_rd_dat[`DATA_DWIDTH] / i_mmu_rd_cell_addr[`ADDR_WIDTH]  in  returned cell beat, data, its SRAM address.
REQ-010 o_mmu_rd_stall  out  1  beat backpressure to MMU.
REQ-011 o_mmu_rd_done  out  1  one-cycle pulse, whole packet delivered.
REQ-012 o_wr_en / o_dat[`DATA_DWIDTH] / o_sop / o_eop  out  output FIFO write; i_full  in  1  output FIFO full.
REQ-013 o_fp_rls_en / o_fp_rls_addr[`ADDR_WIDTH]  out  freed cell address returned to freelist.
REQ-014 o_err  out  1  sticky: descriptor dest != port or cell count 0.

Function
REQ-015 FSM states IDLE, FETCH, REQ, STREAM, DONE; encoding free.
REQ-016 IDLE: if ~i_cb_empty, pulse o_cb_rd_en one cycle, go FETCH; else stay.
REQ-017 FETCH: latch i_cb_dout; if count==0 set o_err, return IDLE with no MMU request; else go REQ (dest mismatch sets o_err but packet still processed).
REQ-018 REQ: hold o_mmu_rd_req=1 with latched addr/len until i_mmu_rd_ready samples 1; deassert req that cycle's next edge; go STREAM.
REQ-019 STREAM: each i_mmu_rd_vld beat enters a 2-entry skid buffer with its cell address; beat counter increments per accepted beat.
REQ-020 o_mmu_rd_stall=1 whenever buffer holds >=1 entry and i_full=1, or holds 2 entries; MMU ceases beats one cycle after stall, so buffer never overflows; beat arriving with buffer full sets o_err and is dropped.
REQ-021 Buffer head written out when non-empty and i_full=0: o_wr_en=1, o_dat=head data; o_sop=1 on beat 1, o_eop=1 on beat count; count==1 gives sop and eop together.
REQ-022 Simultaneous enqueue and dequeue in one cycle keeps occupancy unchanged, order preserved.
REQ-023 Same cycle a beat is written out, o_fp_rls_en=1, o_fp_rls_addr=its cell address.
REQ-024 After eop beat written, go DONE; DONE pulses o_mmu_rd_done one cycle, returns IDLE; next descriptor fetch earliest the cycle after.
REQ-025 Beat counter 7 bits, compares against latched count; no wrap for counts 1..127.
REQ-026 Latency: descriptor available -> o_mmu_rd_req asserted = 2 cycles; beat accepted -> o_wr_en = 1 cycle when i_full=0.

Reset
REQ-027 All outputs 0, FSM IDLE, buffer empty, counters 0, o_err cleared, asynchronously on i_rst_n low.
REQ-028 Reset mid-packet abandons it: no o_mmu_rd_done, no further releases; restart from IDLE.

Configuration
REQ-029 Macro EGRESS_STAT_EN: defined -> adds outputs o_pkt_cnt[32] and o_cell_cnt[32], incremented on o_mmu_rd_done and o_wr_en, wrapping at 2^32, reset 0; undefined -> ports and counters absent.

Verification
REQ-030 port=0, descriptor addr 0x0040 len 3 dest 0 -> req addr 0x0040 len 3; three writes sop on 1st, eop on 3rd; releases 0x0040..cell addrs; one done pulse.
REQ-031 len 1 descriptor -> single write with sop=eop=1, one release, done.
REQ-032 i_full held high 5 cycles mid-stream of len 8 -> stall asserts, no write while full, no beat lost or reordered, 8 writes total.
REQ-033 Descriptor with dest 3 on port=0 instance -> o_err=1, packet still delivered; len 0 descriptor -> o_err=1, no o_mmu_rd_req.
REQ-034 i_rst_n low after 2 of 5 beats -> all outputs 0, no done; next descriptor processed normally.
REQ-035 With EGRESS_STAT_EN, two packets of len 4 and 2 -> o_pkt_cnt=2, o_cell_cnt=6.
